ad9361_tx_burst_pad: RTL and testbench
======================================

Name: ad9361_tx_burst_pad

Overview:
TX-side counterpart of the RX sample filter, which strips quiet samples and keeps NUM_PAD_SAMPS of padding around bursts. This block takes a bursty, framed I/Q stream from upstream logic and rebuilds a contiguous DAC-rate stream for one AD9361 TX channel. Each burst gets leading and trailing zero-padding, and idle/underrun slots are filled with zeros. It sits between the TX sample source (ready/valid/last) and the AD9361 TX data interface (one sample per dac_strobe).

Parameters:
NUM_PAD_SAMPS, 7, zero samples emitted before each burst; 0 allowed.
NUM_TAIL_SAMPS, 7, zero samples emitted after the burst's last sample; 0 allowed.
CNT_WIDTH, 8, pad counter width; must satisfy 2^CNT_WIDTH > max(NUM_PAD_SAMPS, NUM_TAIL_SAMPS).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dac_strobe  in  1  one-cycle pulse per DAC sample slot
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready; combinational
s_data_i  in  12  upstream I, two's complement
s_data_q  in  12  upstream Q, two's complement
s_last  in  1  marks final sample of a burst
valid_out  out  1  one-cycle pulse: output sample updated for this slot
data_i_out  out  12  TX I sample
data_q_out  out  12  TX Q sample
tx_active  out  1  high while state != IDLE
underrun  out  1  sticky: DATA slot found with no upstream sample
underrun_clr  in  1  synchronous clear of underrun

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, valid_out=0, data_i_out=0, data_q_out=0, tx_active=0, underrun=0.
- Events happen only on cycles with dac_strobe=1; on other cycles all registers hold, except valid_out=0 and underrun_clr.
- s_ready = (state==DATA) & dac_strobe. A transfer occurs when s_valid & s_ready. No other state accepts data.
- Outputs are registered. The sample for a strobe at cycle t appears at t+1, with valid_out=1 at t+1 only.
- States:
  - IDLE: on a strobe, emit zero sample with valid_out=0.
    - If s_valid=1: go to PRE_PAD with counter=0, or straight to DATA if NUM_PAD_SAMPS=0.
    - The s_valid sample is not consumed in IDLE.
  - PRE_PAD: each strobe emits zero with valid_out=1 and increments counter. After the NUM_PAD_SAMPS-th pad: counter=0, go to DATA.
  - DATA: each strobe asserts valid_out=1.
    - If s_valid: output {s_data_i, s_data_q}. If s_last, go to POST_PAD with counter=0, or IDLE if NUM_TAIL_SAMPS=0.
    - If !s_valid: output zero, set underrun, stay in DATA. A burst never ends without s_last.
  - POST_PAD: each strobe emits zero with valid_out=1. After NUM_TAIL_SAMPS pads, go to IDLE.
- tx_active reflects the registered state; it rises on the cycle after the first strobe that leaves IDLE.
- s_last with !s_valid is ignored.
- underrun_clr and an underrun set in the same cycle: set wins.
- Back-to-back bursts: the next burst always re-enters via IDLE. Each burst costs one idle slot plus pads.
- Reset mid-burst: state returns to IDLE immediately. The partially consumed upstream burst is the source's responsibility; no residue is kept.
- Counter saturation is impossible by the CNT_WIDTH constraint; no wraparound logic.
- Data is passed bit-exact, with no scaling or sign handling.

Test Plan:
- Basic burst: strobe every 4 clk; NUM_PAD_SAMPS=7, NUM_TAIL_SAMPS=7; 3 samples (0x123/0x456, 0x7FF/0x800, 0x001/0xFFF, last on 3rd).
  - valid_out pattern: 7 zeros, the 3 samples in order, 7 zeros.
  - tx_active high for exactly 17 strobe slots; s_ready pulses exactly 3 times.
- Zero pads: NUM_PAD_SAMPS=0, NUM_TAIL_SAMPS=0, single sample with s_last.
  - Expected sequence: IDLE slot, one valid_out carrying the sample, then IDLE.
  - No zero valid_out pulses.
- Underrun: drop s_valid for 2 strobes mid-burst.
  - Two zero samples with valid_out=1 at those slots; underrun=1 and stays set.
  - underrun_clr pulse clears it; underrun_clr coincident with a new underrun leaves it set.
- Continuous strobe (dac_strobe tied high), 2 back-to-back 4-sample bursts.
  - One idle slot plus 7 pre-pads between bursts; no sample lost or duplicated (compare against scoreboard).
- Async reset asserted during PRE_PAD count 3, released mid-cycle.
  - All outputs 0 immediately (no clock needed); next burst gets a full 7-sample pre-pad.
- s_valid held high with no dac_strobe for 50 clk.
  - s_ready stays 0, valid_out stays 0, state stays IDLE.

Source files
------------

// File: rtl/ad9361_tx_burst_pad.sv
`default_nettype none
// ============================================================================
// Module      : ad9361_tx_burst_pad
// Description : Turns a bursty ready/valid/last I/Q stream into a contiguous
//               DAC-rate stream for one AD9361 TX channel. Each burst gets
//               NUM_PAD_SAMPS leading zeros and NUM_TAIL_SAMPS trailing zeros.
//               Idle and underrun slots are filled with zeros.
// Ports       : clk, rst_n              - core clock, async active-low reset
//               dac_strobe              - one pulse per DAC sample slot
//               s_valid/s_ready/s_last  - upstream handshake (s_ready comb.)
//               s_data_i/s_data_q       - upstream 12-bit I/Q
//               valid_out               - pulse: output sample updated
//               data_i_out/data_q_out   - registered TX sample
//               tx_active               - high while not idle
//               underrun, underrun_clr  - sticky underrun flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module ad9361_tx_burst_pad #(
  parameter int NUM_PAD_SAMPS  = 7,
  parameter int NUM_TAIL_SAMPS = 7,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dac_strobe,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data_i,
  input  logic [11:0] s_data_q,
  input  logic        s_last,
  output logic        valid_out,
  output logic [11:0] data_i_out,
  output logic [11:0] data_q_out,
  output logic        tx_active,
  output logic        underrun,
  input  logic        underrun_clr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRE_PAD  = 2'd1,
    S_DATA     = 2'd2,
    S_POST_PAD = 2'd3
  } state_t;

  // Terminal counter values; only reached when the matching pad count is
  // non-zero, so the zero-pad case never compares against them.
  localparam logic [CNT_WIDTH-1:0] c_pad_last  =
    (NUM_PAD_SAMPS  > 0) ? CNT_WIDTH'(NUM_PAD_SAMPS  - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] c_tail_last =
    (NUM_TAIL_SAMPS > 0) ? CNT_WIDTH'(NUM_TAIL_SAMPS - 1) : '0;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  assign s_ready   = (r_state == S_DATA) & dac_strobe;
  assign tx_active = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      valid_out  <= 1'b0;
      data_i_out <= '0;
      data_q_out <= '0;
      underrun   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      // Clear first so a same-cycle underrun set below takes priority.
      if (underrun_clr) begin
        underrun <= 1'b0;
      end
      if (dac_strobe) begin
        case (r_state)
          S_IDLE: begin
            data_i_out <= '0;
            data_q_out <= '0;
            // The waiting sample is left upstream; it is consumed in DATA.
            if (s_valid) begin
              r_cnt   <= '0;
              r_state <= (NUM_PAD_SAMPS == 0) ? S_DATA : S_PRE_PAD;
            end
          end
          S_PRE_PAD: begin
            valid_out  <= 1'b1;
            data_i_out <= '0;
            data_q_out <= '0;
            if (r_cnt == c_pad_last) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DATA: begin
            valid_out <= 1'b1;
            if (s_valid) begin
              data_i_out <= s_data_i;
              data_q_out <= s_data_q;
              if (s_last) begin
                r_cnt   <= '0;
                r_state <= (NUM_TAIL_SAMPS == 0) ? S_IDLE : S_POST_PAD;
              end
            end else begin
              // Keep the DAC fed with zeros; the burst continues until s_last.
              data_i_out <= '0;
              data_q_out <= '0;
              underrun   <= 1'b1;
            end
          end
          S_POST_PAD: begin
            valid_out  <= 1'b1;
            data_i_out <= '0;
            data_q_out <= '0;
            if (r_cnt == c_tail_last) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad9361_tx_burst_pad.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad9361_tx_burst_pad
// Description : Directed self-checking bench for ad9361_tx_burst_pad. Two
//               instances: default padding (7/7) and zero padding (0/0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad9361_tx_burst_pad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dac_strobe = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [11:0] s_data_i = '0;
  logic [11:0] s_data_q = '0;

  logic        a_ready, a_valid, a_act, a_und;
  logic [11:0] a_di, a_dq;
  logic        b_ready, b_valid, b_act, b_und;
  logic [11:0] b_di, b_dq;

  ad9361_tx_burst_pad #(.NUM_PAD_SAMPS(7), .NUM_TAIL_SAMPS(7), .CNT_WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .dac_strobe(dac_strobe), .s_valid(s_valid),
    .s_ready(a_ready), .s_data_i(s_data_i), .s_data_q(s_data_q), .s_last(s_last),
    .valid_out(a_valid), .data_i_out(a_di), .data_q_out(a_dq),
    .tx_active(a_act), .underrun(a_und), .underrun_clr(underrun_clr)
  );

  ad9361_tx_burst_pad #(.NUM_PAD_SAMPS(0), .NUM_TAIL_SAMPS(0), .CNT_WIDTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .dac_strobe(dac_strobe), .s_valid(s_valid),
    .s_ready(b_ready), .s_data_i(s_data_i), .s_data_q(s_data_q), .s_last(s_last),
    .valid_out(b_valid), .data_i_out(b_di), .data_q_out(b_dq),
    .tx_active(b_act), .underrun(b_und), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  // Selects which instance the slot/burst helpers observe.
  logic        sel = 1'b0;
  logic        obs_ready, obs_valid, obs_act, obs_und;
  logic [11:0] obs_di, obs_dq;
  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_act   = sel ? b_act   : a_act;
  assign obs_und   = sel ? b_und   : a_und;
  assign obs_di    = sel ? b_di    : a_di;
  assign obs_dq    = sel ? b_dq    : a_dq;

  typedef struct packed {
    logic        v;
    logic [11:0] i;
    logic [11:0] q;
    logic        act;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_ready = 0;
  int          n_act = 0;
  logic [11:0] bi[8];
  logic [11:0] bq[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   a_valid, 0);
    chk({tag, "_data_i"},  a_di,    0);
    chk({tag, "_data_q"},  a_dq,    0);
    chk({tag, "_active"},  a_act,   0);
    chk({tag, "_underrun"}, a_und,  0);
    chk({tag, "_ready"},   a_ready, 0);
  endtask

  // One DAC slot: drive inputs with the strobe, check s_ready, queue the
  // expected registered output, then compare it after the edge. 'gap' is the
  // slot period in clocks; the strobe-free cycles must show valid_out low.
  task automatic slot(input int gap, input logic v, input logic [11:0] di,
                      input logic [11:0] dq, input logic last,
                      input logic e_ready, input logic e_valid,
                      input logic [11:0] ei, input logic [11:0] eq,
                      input logic e_act);
    exp_t e;
    exp_t g;
    s_valid    = v;
    s_data_i   = di;
    s_data_q   = dq;
    s_last     = last;
    dac_strobe = 1'b1;
    #1;
    chk("s_ready", obs_ready, e_ready);
    if (obs_ready) n_ready++;
    if (obs_act) n_act++;
    e.v = e_valid; e.i = ei; e.q = eq; e.act = e_act;
    sb.push_back(e);
    @(posedge clk); #1;
    dac_strobe   = 1'b0;
    underrun_clr = 1'b0;
    g = sb.pop_front();
    chk("valid_out",  obs_valid, g.v);
    chk("data_i_out", obs_di,    g.i);
    chk("data_q_out", obs_dq,    g.q);
    chk("tx_active",  obs_act,   g.act);
    for (int c = 1; c < gap; c++) begin
      @(posedge clk); #1;
      chk("valid_gap", obs_valid, 0);
    end
  endtask

  // Full burst of n samples from bi/bq. drop_cnt underrun slots are inserted
  // before sample index drop_at (s_last is driven high there to show it is
  // ignored without s_valid); clr_drop pulses underrun_clr on those slots.
  task automatic run_burst(input int n, input int gap, input int drop_at,
                           input int drop_cnt, input logic clr_drop);
    int pad;
    int tail;
    int k;
    int d;
    pad  = sel ? 0 : 7;
    tail = sel ? 0 : 7;
    k = 0;
    d = 0;
    slot(gap, 1'b1, bi[0], bq[0], n == 1, 1'b0, 1'b0, 12'h0, 12'h0, 1'b1);
    for (int p = 0; p < pad; p++)
      slot(gap, 1'b1, bi[0], bq[0], n == 1, 1'b0, 1'b1, 12'h0, 12'h0, 1'b1);
    while (k < n) begin
      if (k == drop_at && d < drop_cnt) begin
        underrun_clr = clr_drop;
        slot(gap, 1'b0, 12'hEEE, 12'hDDD, 1'b1, 1'b1, 1'b1, 12'h0, 12'h0, 1'b1);
        d++;
      end else begin
        slot(gap, 1'b1, bi[k], bq[k], k == n - 1, 1'b1, 1'b1, bi[k], bq[k],
             !(k == n - 1 && tail == 0));
        k++;
      end
    end
    if (drop_cnt > 0) chk("underrun_set", obs_und, 1);
    for (int p = 0; p < tail; p++)
      slot(gap, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1, 12'h0, 12'h0, p != tail - 1);
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      bi[k] = 12'($urandom);
      bq[k] = 12'($urandom);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // s_valid high with no strobe: nothing may move
    s_valid  = 1'b1;
    s_data_i = 12'hABC;
    s_data_q = 12'h321;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      chk("nostrobe_ready",  a_ready, 0);
      chk("nostrobe_valid",  a_valid, 0);
      chk("nostrobe_active", a_act,   0);
    end
    s_valid = 1'b0;

    // Zero-pad instance: idle slot, one data slot, back to idle
    sel   = 1'b1;
    bi[0] = 12'h5A5;
    bq[0] = 12'hA5A;
    run_burst(1, 4, -1, 0, 1'b0);
    slot(4, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    sel = 1'b0;

    // The 7/7 instance saw the same strobes; restart it cleanly
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst, strobe every 4 clocks
    n_ready = 0;
    n_act   = 0;
    bi[0] = 12'h123; bq[0] = 12'h456;
    bi[1] = 12'h7FF; bq[1] = 12'h800;
    bi[2] = 12'h001; bq[2] = 12'hFFF;
    run_burst(3, 4, -1, 0, 1'b0);
    chk("basic_ready_pulses", n_ready, 3);
    chk("basic_active_slots", n_act, 17);
    chk("basic_no_underrun", a_und, 0);

    // Underrun: two empty data slots mid-burst, flag stays set
    fill_random(4);
    run_burst(4, 2, 1, 2, 1'b0);
    chk("underrun_sticky", a_und, 1);
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    chk("underrun_cleared", a_und, 0);
    // Clear coincident with a new underrun: set wins
    fill_random(2);
    run_burst(2, 2, 1, 1, 1'b1);
    chk("underrun_set_wins", a_und, 1);

    // Continuous strobe, two back-to-back 4-sample bursts
    fill_random(4);
    run_burst(4, 1, -1, 0, 1'b0);
    fill_random(4);
    run_burst(4, 1, -1, 0, 1'b0);

    // Async reset during pre-pad, after three pads
    fill_random(2);
    slot(1, 1'b1, bi[0], bq[0], 1'b0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b1);
    for (int p = 0; p < 3; p++)
      slot(1, 1'b1, bi[0], bq[0], 1'b0, 1'b0, 1'b1, 12'h0, 12'h0, 1'b1);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(2, 2, -1, 0, 1'b0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
